// File: rtl/conv_bcd_div_pkg.sv
// Shared definitions for the quotient-to-BCD conversion stage that sits
// between the restoring divider and the 7-segment display driver.
package pkg_ula;

  // Control states of the converter.
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,  // waiting for an operand
    CONVERTE = 2'd1,  // one double-dabble iteration per clock
    PRONTO   = 2'd2   // result presented, waiting for the display stage
  } estado_t;

  // Width of the BCD accumulator: three 4-bit digits.
  localparam int LARG_BCD = 12;

  // Digit code the display decodes as a blank segment group.
  localparam logic [3:0] APAGADO = 4'hF;

endpackage : pkg_ula

// File: rtl/conv_bcd_div_ajuste_bcd.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next
// decade.
module ajuste_bcd (
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  // Pure combinational correction; the digit never exceeds 9 here, so the
  // sum fits in 4 bits.
  assign digito_o = (digito_i >= 4'd5) ? (digito_i + 4'd3) : digito_i;

endmodule : ajuste_bcd

// File: rtl/conv_bcd_div.sv
// Sequential binary-to-BCD converter for the divider quotient. Accepts the
// quotient plus the remainder and divide-by-zero flags, converts one bit per
// clock with shift-and-add-3, and holds the three digits and flags for the
// display stage under a valid/ready handshake.
module conv_bcd_div #(
  parameter int         LARG    = 8,
  parameter logic [3:0] APAGADO = pkg_ula::APAGADO
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LARG-1:0] quociente,
  input  logic            r_exists,
  input  logic            erro,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      centenas,
  output logic [3:0]      dezenas,
  output logic [3:0]      unidades,
  output logic            r_flag,
  output logic            erro_flag
);

  import pkg_ula::*;

  // Counter wide enough to hold LARG-1; a single bit is kept for LARG=1.
  localparam int CW = (LARG > 1) ? $clog2(LARG) : 1;
  localparam logic [CW-1:0] ULTIMA_ITER = CW'(LARG - 1);

  // Control and datapath state.
  estado_t               estado_q;
  logic [CW-1:0]         cont_q;
  logic [LARG-1:0]       bin_q;
  logic [LARG_BCD-1:0]   bcd_q;
  logic                  r_q;
  logic                  erro_q;

  // Output registers.
  logic [3:0]            centenas_q;
  logic [3:0]            dezenas_q;
  logic [3:0]            unidades_q;
  logic                  r_flag_q;
  logic                  erro_flag_q;

  // Next value of the {BCD, binary} shift pair for one iteration.
  logic [LARG_BCD-1:0]      bcd_ajustado;
  logic [LARG_BCD+LARG-1:0] desloc_d;
  logic [LARG_BCD-1:0]      bcd_d;
  logic [LARG-1:0]          bin_d;

  // One correction cell per decade, all applied before the shift.
  for (genvar g = 0; g < LARG_BCD / 4; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .digito_i (bcd_q[4*g +: 4]),
      .digito_o (bcd_ajustado[4*g +: 4])
    );
  end

  // Corrected digits and remaining binary bits shift left together, so the
  // binary MSB enters the units digit LSB.
  assign desloc_d = {bcd_ajustado, bin_q} << 1;
  assign bcd_d    = desloc_d[LARG_BCD+LARG-1 -: LARG_BCD];
  assign bin_d    = desloc_d[LARG-1:0];

  // Handshake outputs depend only on the state register, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (estado_q == OCIOSO);
  assign out_valid = (estado_q == PRONTO);

  assign centenas  = centenas_q;
  assign dezenas   = dezenas_q;
  assign unidades  = unidades_q;
  assign r_flag    = r_flag_q;
  assign erro_flag = erro_flag_q;

  // Controller, iteration counter, shift registers and output registers.
  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // a blocking assignment would let the shift read its own freshly written
  // state within the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      cont_q      <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      r_q         <= 1'b0;
      erro_q      <= 1'b0;
      centenas_q  <= 4'd0;
      dezenas_q   <= 4'd0;
      unidades_q  <= 4'd0;
      r_flag_q    <= 1'b0;
      erro_flag_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (in_valid && in_ready) begin
            bin_q  <= quociente;
            bcd_q  <= '0;
            r_q    <= r_exists;
            erro_q <= erro;
            cont_q <= '0;
            if (erro) begin
              // Divide-by-zero: nothing to convert, show a blank display.
              centenas_q  <= APAGADO;
              dezenas_q   <= APAGADO;
              unidades_q  <= APAGADO;
              r_flag_q    <= 1'b0;
              erro_flag_q <= 1'b1;
              estado_q    <= PRONTO;
            end else begin
              estado_q <= CONVERTE;
            end
          end
        end

        CONVERTE: begin
          bcd_q  <= bcd_d;
          bin_q  <= bin_d;
          cont_q <= cont_q + 1'b1;
          if (cont_q == ULTIMA_ITER) begin
            // Last bit shifted in: the next accumulator value is the result.
            centenas_q  <= bcd_d[11:8];
            dezenas_q   <= bcd_d[7:4];
            unidades_q  <= bcd_d[3:0];
            r_flag_q    <= r_q;
            erro_flag_q <= erro_q;
            estado_q    <= PRONTO;
          end
        end

        PRONTO: begin
          // Outputs stay frozen until the display stage takes them.
          if (out_ready) begin
            estado_q <= OCIOSO;
          end
        end

        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

endmodule : conv_bcd_div
